regfile_pc_param: RTL and testbench

Parametrised register file for the pipeline's decode stage: NREG general registers of DW bits, NRP combinational read ports and one synchronous write port. One entry (index PC_IDX) is the program counter, with its own load path and auto-increment. A clocked 4-bit condition-flag register sits alongside it. Decode reads operands and PC from this block; writeback drives the write port, and the fetch/branch logic drives the PC controls.

---
 rtl/regfile_pc_param.sv | 103 ++++++++++
 tb/tb_regfile_pc_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_pc_param.sv
// ============================================================================
// regfile_pc_param -- decode-stage register file with integrated PC and flags.
// Optional macro RF_BYPASS_EN forwards the write port to the read ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_pc_param #(
  parameter int              DW     = 32,
  parameter int              NREG   = 16,
  parameter int              AW     = $clog2(NREG),
  parameter int              NRP    = 3,
  parameter int              PC_IDX = NREG - 1,
  parameter logic [DW-1:0]   PC_INC = DW'(4),
  parameter logic [DW-1:0]   PC_RST = '0
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [DW-1:0]       wd,
  input  logic [NRP*AW-1:0]   ra,
  output logic [NRP*DW-1:0]   rd,
  input  logic                pc_ld,
  input  logic [DW-1:0]       pc_in,
  input  logic                pc_stall,
  output logic [DW-1:0]       pc_out,
  input  logic                flag_ld,
  input  logic [3:0]          flag_in,
  output logic [3:0]          flags
);

  logic [DW-1:0] w_ent [NREG];
  logic [DW-1:0] r_pc;
  logic [3:0]    r_flags;
  logic          w_wr_ok;
  logic          w_wr_pc;

  assign w_wr_ok = we && (32'(wa) < NREG) && (32'(wa) != PC_IDX);
  assign w_wr_pc = we && (32'(wa) == PC_IDX);

  // Each entry is its own generate block so the PC slot can alias r_pc.
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (i != PC_IDX) begin : g_gen
      logic [DW-1:0] r_q;
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          r_q <= '0;
        end else if (w_wr_ok && (wa == AW'(i))) begin
          r_q <= wd;
        end
      end
      assign w_ent[i] = r_q;
    end else begin : g_pc
      assign w_ent[i] = r_pc;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_pc <= PC_RST;
    end else if (pc_ld) begin
      r_pc <= pc_in;
    end else if (w_wr_pc) begin
      r_pc <= wd;
    end else if (!pc_stall) begin
      r_pc <= r_pc + PC_INC;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_flags <= 4'b0000;
    end else if (flag_ld) begin
      r_flags <= flag_in;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rp
    logic [AW-1:0] w_a;
    logic [DW-1:0] w_d;
    assign w_a = ra[p*AW +: AW];
    always_comb begin
      w_d = '0;
      if (32'(w_a) < NREG) begin
        w_d = w_ent[w_a];
      end
`ifdef RF_BYPASS_EN
      // w_wr_ok already excludes the PC entry, so PC reads stay registered.
      if (w_wr_ok && (wa == w_a)) begin
        w_d = wd;
      end
`endif
    end
    assign rd[p*DW +: DW] = w_d;
  end

  assign pc_out = r_pc;
  assign flags  = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_regfile_pc_param.sv
// Testbench for regfile_pc_param: behavioural model checked every cycle plus
// directed literal expectations, and a second NREG=12 instance for range checks.
`default_nettype none

module tb_regfile_pc_param;

  logic        clk = 1'b0;
  logic        clr;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic [11:0] ra;
  logic [95:0] rd;
  logic        pc_ld;
  logic [31:0] pc_in;
  logic        pc_stall;
  logic [31:0] pc_out;
  logic        flag_ld;
  logic [3:0]  flag_in;
  logic [3:0]  flags;

  logic        s_we;
  logic [3:0]  s_wa;
  logic [31:0] s_wd;
  logic [3:0]  s_ra;
  logic [31:0] s_rd;
  logic [31:0] s_pc_out;
  logic [3:0]  s_flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_pc_param dut (
    .clk(clk), .clr(clr), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .pc_ld(pc_ld), .pc_in(pc_in), .pc_stall(pc_stall), .pc_out(pc_out),
    .flag_ld(flag_ld), .flag_in(flag_in), .flags(flags)
  );

  regfile_pc_param #(.NREG(12), .NRP(1)) dut12 (
    .clk(clk), .clr(clr), .we(s_we), .wa(s_wa), .wd(s_wd), .ra(s_ra), .rd(s_rd),
    .pc_ld(1'b0), .pc_in(32'h0), .pc_stall(1'b1), .pc_out(s_pc_out),
    .flag_ld(1'b0), .flag_in(4'h0), .flags(s_flags)
  );

  // Reference model of the 16-entry, 3-port default configuration.
  logic [31:0] m_regs [16];
  logic [31:0] m_pc;
  logic [3:0]  m_flags;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
      m_pc    = 32'h0;
      m_flags = 4'h0;
    end else begin
      if (we && wa != 4'd15) m_regs[wa] = wd;
      if (pc_ld)                  m_pc = pc_in;
      else if (we && wa == 4'd15) m_pc = wd;
      else if (!pc_stall)         m_pc = m_pc + 32'd4;
      if (flag_ld) m_flags = flag_in;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (a == 4'd15) return m_pc;
`ifdef RF_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_regs[a];
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < 3; p++)
      chk($sformatf("model_rd%0d", p), 96'(rd[p*32 +: 32]), 96'(exp_rd(ra[p*4 +: 4])));
    chk("model_pc", 96'(pc_out), 96'(m_pc));
    chk("model_flags", 96'(flags), 96'(m_flags));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
    pc_ld = 1'b0; pc_in = '0; pc_stall = 1'b0; flag_ld = 1'b0; flag_in = '0;
    s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra = '0;
    repeat (2) step();
    chk("reset_pc", 96'(pc_out), 96'(0));
    chk("reset_flags", 96'(flags), 96'(0));
    chk("reset_rd", rd, 96'(0));
    clr = 1'b0;
    repeat (3) step();
    chk("pc_after_3", 96'(pc_out), 96'(12));

    #1 clr = 1'b1;
    #1 chk("async_clr_pc", 96'(pc_out), 96'(0));
    #1 clr = 1'b0;

    pc_stall = 1'b1;
    step();
    we = 1'b1; wa = 4'd10; wd = 32'h000A0000;
    step();
    wa = 4'd3; wd = 32'hDEADBEEF;
    step();
    we = 1'b0; wa = 4'd3; wd = 32'h11111111;
    ra = {4'd10, 4'd3, 4'd10};
    step();
    chk("read_3port", rd, {32'h000A0000, 32'hDEADBEEF, 32'h000A0000});

    pc_ld = 1'b1; pc_in = 32'h00001000; we = 1'b1; wa = 4'd15; wd = 32'h00002000;
    pc_stall = 1'b0;
    step();
    pc_ld = 1'b0; we = 1'b0; pc_stall = 1'b1;
    chk("pc_ld_wins", 96'(pc_out), 96'(32'h00001000));
    step();
    chk("pc_stall", 96'(pc_out), 96'(32'h00001000));
    pc_stall = 1'b0;
    step();
    chk("pc_inc", 96'(pc_out), 96'(32'h00001004));
    pc_ld = 1'b1; pc_in = 32'hFFFFFFFC; pc_stall = 1'b1;
    step();
    pc_ld = 1'b0; pc_stall = 1'b0;
    chk("pc_ld_over_stall", 96'(pc_out), 96'(32'hFFFFFFFC));
    step();
    chk("pc_wrap", 96'(pc_out), 96'(0));

    pc_stall = 1'b1;
    ra = {4'd0, 4'd0, 4'd5};
    we = 1'b1; wa = 4'd5; wd = 32'h12345678;
    #1;
`ifdef RF_BYPASS_EN
    chk("bypass_pre_edge", 96'(rd[31:0]), 96'(32'h12345678));
`else
    chk("no_bypass_pre_edge", 96'(rd[31:0]), 96'(0));
`endif
    step();
    we = 1'b0;
    chk("write_visible", 96'(rd[31:0]), 96'(32'h12345678));
    ra = {4'd0, 4'd0, 4'd15};
    we = 1'b1; wa = 4'd15; wd = 32'hCAFEF00D;
    #1 chk("pc_never_bypassed", 96'(rd[31:0]), 96'(0));
    step();
    we = 1'b0;
    chk("pc_write_port", 96'(pc_out), 96'(32'hCAFEF00D));

    flag_ld = 1'b1; flag_in = 4'b1010;
    step();
    flag_ld = 1'b0; flag_in = 4'b0101;
    chk("flags_load", 96'(flags), 96'(4'b1010));
    step();
    chk("flags_hold", 96'(flags), 96'(4'b1010));

    // Mixed traffic: writes to every general register while PC runs.
    pc_stall = 1'b0;
    for (int i = 0; i < 15; i++) begin
      we = 1'b1; wa = 4'(i); wd = 32'h01010101 * (i + 1);
      ra = {4'(14 - i), 4'(i), 4'(i + 1)};
      flag_ld = i[0]; flag_in = 4'(i);
      step();
    end
    we = 1'b0; flag_ld = 1'b0;
    ra = {4'd7, 4'd0, 4'd14};
    step();
    chk("r14_direct", 96'(rd[31:0]), 96'(32'h0F0F0F0F));

    s_we = 1'b1; s_wa = 4'd13; s_wd = 32'hFFFFFFFF;
    step();
    s_wa = 4'd4; s_wd = 32'hA5A5A5A5;
    step();
    s_we = 1'b0;
    for (int a = 0; a < 16; a++) begin
      s_ra = 4'(a);
      #1 chk($sformatf("n12_rd%0d", a), 96'(s_rd), 96'((a == 4) ? 32'hA5A5A5A5 : 32'h0));
    end
    chk("n12_pc", 96'(s_pc_out), 96'(0));

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
